// File: rtl/cache_req_arbiter_rr.sv
// rtl/cache_req_arbiter_rr.sv - four-requester slot arbiter with round-robin or fixed-priority merge
// Each requester owns a one-entry slot; a single output register drains the winning slot.
module cache_req_arbiter_rr #(
    parameter int DATA_WIDTH    = 6,
    parameter int PRIORITY_MODE = 0
) (
    input  logic                    clk,
    input  logic                    rstn,
    input  logic [3:0]              in_valid,
    output logic [3:0]              in_ready,
    input  logic [4*DATA_WIDTH-1:0] in_data,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [DATA_WIDTH-1:0]   out_data,
    output logic [1:0]              out_src,
    output logic                    busy
);

    typedef enum logic {
        ST_EMPTY = 1'b0,
        ST_HOLD  = 1'b1
    } state_t;

    state_t                r_state;
    state_t                w_state_nxt;
    logic [3:0]            r_slot_full;
    logic [DATA_WIDTH-1:0] r_slot_data [4];
    logic [1:0]            r_ptr;
    logic [DATA_WIDTH-1:0] r_out_data;
    logic [1:0]            r_out_src;

    logic [1:0]            w_scan [4];
    logic [1:0]            w_win;
    logic                  w_load;
    logic [3:0]            w_accept;

    // Scan order: fixed mode always starts at 0, round-robin starts at the pointer.
    always_comb begin
        for (int k = 0; k < 4; k++) begin
            w_scan[k] = (PRIORITY_MODE != 0) ? 2'(k) : r_ptr + 2'(k);
        end
    end

    // Walk the scan order backwards so the earliest full slot is the final assignment.
    always_comb begin
        w_win = 2'd0;
        for (int k = 3; k >= 0; k--) begin
            if (r_slot_full[w_scan[k]]) begin
                w_win = w_scan[k];
            end
        end
    end

    assign w_load   = ((r_state == ST_EMPTY) || out_ready) && (|r_slot_full);
    assign w_accept = in_valid & ~r_slot_full;

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_EMPTY: if (w_load) w_state_nxt = ST_HOLD;
            ST_HOLD:  if (!w_load && out_ready) w_state_nxt = ST_EMPTY;
            default:  w_state_nxt = ST_EMPTY;
        endcase
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_state     <= ST_EMPTY;
            r_slot_full <= 4'b0000;
            r_ptr       <= 2'd0;
            r_out_data  <= '0;
            r_out_src   <= 2'd0;
            for (int i = 0; i < 4; i++) begin
                r_slot_data[i] <= '0;
            end
        end else begin
            r_state <= w_state_nxt;
            // A slot being drained is full, so it cannot also be accepting this edge.
            for (int i = 0; i < 4; i++) begin
                if (w_accept[i]) begin
                    r_slot_full[i] <= 1'b1;
                    r_slot_data[i] <= in_data[i*DATA_WIDTH +: DATA_WIDTH];
                end else if (w_load && (w_win == 2'(i))) begin
                    r_slot_full[i] <= 1'b0;
                end
            end
            if (w_load) begin
                r_out_data <= r_slot_data[w_win];
                r_out_src  <= w_win;
                r_ptr      <= w_win + 2'd1;
            end
        end
    end

    assign in_ready  = ~r_slot_full;
    assign out_valid = (r_state == ST_HOLD);
    assign out_data  = r_out_data;
    assign out_src   = r_out_src;
    assign busy      = (|r_slot_full) | out_valid;

endmodule

// File: tb/tb_cache_req_arbiter_rr.sv
// tb/tb_cache_req_arbiter_rr.sv - vector, directed and random scoreboard bench for cache_req_arbiter_rr
module tb_cache_req_arbiter_rr;
    localparam int DW = 6;

    logic            clk = 1'b0;
    logic            rstn;
    logic [3:0]      in_valid;
    logic [4*DW-1:0] in_data;
    logic            out_ready;

    logic [3:0]      ir0, ir1;
    logic            ov0, ov1, bz0, bz1;
    logic [DW-1:0]   od0, od1;
    logic [1:0]      os0, os1;

    cache_req_arbiter_rr #(.DATA_WIDTH(DW), .PRIORITY_MODE(0)) dut_rr (
        .clk(clk), .rstn(rstn), .in_valid(in_valid), .in_ready(ir0), .in_data(in_data),
        .out_valid(ov0), .out_ready(out_ready), .out_data(od0), .out_src(os0), .busy(bz0)
    );

    cache_req_arbiter_rr #(.DATA_WIDTH(DW), .PRIORITY_MODE(1)) dut_fp (
        .clk(clk), .rstn(rstn), .in_valid(in_valid), .in_ready(ir1), .in_data(in_data),
        .out_valid(ov1), .out_ready(out_ready), .out_data(od1), .out_src(os1), .busy(bz1)
    );

    always #5 clk = ~clk;

    int n_chk = 0;
    int n_err = 0;

    // Reference model state per instance (0 = round-robin, 1 = fixed priority)
    bit            mf   [2][4];
    logic [DW-1:0] md   [2][4];
    int            mptr [2];
    bit            mov  [2];
    logic [DW-1:0] mod_ [2];
    int            msrc [2];

    logic [DW-1:0] sbq [4][$];
    int            waitc [4];
    int            max_wait = 0;

    typedef struct {
        bit            do_reset;
        logic [3:0]    iv;
        logic [4*DW-1:0] id;
        bit            ordy;
        logic          ev;
        logic [DW-1:0] ed;
        logic [1:0]    es;
        logic [3:0]    eir;
        logic          eb;
    } vec_t;

    vec_t tbl [18];

    function automatic vec_t mkv(bit r, logic [3:0] iv, logic [4*DW-1:0] id, bit ordy,
                                 logic ev, logic [DW-1:0] ed, logic [1:0] es, logic [3:0] eir, logic eb);
        vec_t v;
        v.do_reset = r; v.iv = iv; v.id = id; v.ordy = ordy;
        v.ev = ev; v.ed = ed; v.es = es; v.eir = eir; v.eb = eb;
        return v;
    endfunction

    task automatic chk(string nm, int idx, logic [31:0] act, logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s[%0d] actual=%h expected=%h", nm, idx, act, exp);
        end
    endtask

    task automatic model_reset();
        for (int m = 0; m < 2; m++) begin
            for (int i = 0; i < 4; i++) begin
                mf[m][i] = 1'b0;
                md[m][i] = '0;
            end
            mptr[m] = 0; mov[m] = 1'b0; mod_[m] = '0; msrc[m] = 0;
        end
    endtask

    task automatic model_step(int m, logic [3:0] iv, logic [4*DW-1:0] id, bit ordy);
        bit snap [4];
        bit any;
        int win;
        int idx;
        any = 1'b0;
        for (int i = 0; i < 4; i++) begin
            snap[i] = mf[m][i];
            any |= snap[i];
        end
        if ((!mov[m] || ordy) && any) begin
            win = -1;
            for (int k = 0; k < 4; k++) begin
                idx = (m == 1) ? k : (mptr[m] + k) % 4;
                if (win < 0 && snap[idx]) win = idx;
            end
            mod_[m] = md[m][win];
            msrc[m] = win;
            mf[m][win] = 1'b0;
            mptr[m] = (win + 1) % 4;
            mov[m] = 1'b1;
        end else if (mov[m] && ordy) begin
            mov[m] = 1'b0;
        end
        for (int i = 0; i < 4; i++) begin
            if (iv[i] && !snap[i]) begin
                mf[m][i] = 1'b1;
                md[m][i] = id[i*DW +: DW];
            end
        end
    endtask

    function automatic logic [13:0] model_pack(int m);
        logic [3:0] ir;
        logic       any;
        any = 1'b0;
        for (int i = 0; i < 4; i++) begin
            ir[i] = ~mf[m][i];
            any |= mf[m][i];
        end
        return {mov[m], mod_[m], 2'(msrc[m]), ir, any | mov[m]};
    endfunction

    task automatic do_reset();
        #2 rstn = 1'b0;
        in_valid = 4'b0000; in_data = '0; out_ready = 1'b0;
        #1;
        chk("reset_rr", 0, {18'd0, ov0, od0, os0, ir0, bz0}, {18'd0, 1'b0, 6'd0, 2'd0, 4'hF, 1'b0});
        chk("reset_fp", 0, {18'd0, ov1, od1, os1, ir1, bz1}, {18'd0, 1'b0, 6'd0, 2'd0, 4'hF, 1'b0});
        model_reset();
        for (int i = 0; i < 4; i++) begin
            sbq[i].delete();
            waitc[i] = 0;
        end
        #3 rstn = 1'b1;
    endtask

    task automatic step(logic [3:0] iv, logic [4*DW-1:0] id, bit ordy);
        logic [DW-1:0] hold_d;
        logic [1:0]    hold_s;
        bit            stall;
        bit            ld_obs;
        logic [3:0]    full_obs;
        logic [DW-1:0] exp_d;
        in_valid = iv; in_data = id; out_ready = ordy;
        for (int i = 0; i < 4; i++) begin
            if (iv[i] && ir0[i]) sbq[i].push_back(id[i*DW +: DW]);
        end
        if (ov0 && ordy) begin
            if (sbq[os0].size() == 0) begin
                chk("sb_unexpected_beat", int'(os0), 32'd1, 32'd0);
            end else begin
                exp_d = sbq[os0].pop_front();
                chk("sb_data", int'(os0), {26'd0, od0}, {26'd0, exp_d});
            end
        end
        stall = ov0 && !ordy;
        hold_d = od0; hold_s = os0;
        full_obs = ~ir0;
        ld_obs = (!ov0 || ordy) && (|full_obs);
        model_step(0, iv, id, ordy);
        model_step(1, iv, id, ordy);
        @(posedge clk);
        #1;
        chk("model_rr", 0, {18'd0, ov0, od0, os0, ir0, bz0}, {18'd0, model_pack(0)});
        chk("model_fp", 1, {18'd0, ov1, od1, os1, ir1, bz1}, {18'd0, model_pack(1)});
        if (stall) chk("stall_hold", 0, {23'd0, ov0, od0, os0}, {23'd0, 1'b1, hold_d, hold_s});
        if (ld_obs) begin
            for (int i = 0; i < 4; i++) begin
                if (full_obs[i]) begin
                    waitc[i]++;
                    if (2'(i) == os0) begin
                        if (waitc[i] > max_wait) max_wait = waitc[i];
                        waitc[i] = 0;
                    end
                end
            end
        end
    endtask

    initial begin
        bit f0;
        rstn = 1'b1; in_valid = '0; in_data = '0; out_ready = 1'b0;
        #1;
        do_reset();

        tbl[0]  = mkv(0, 4'b0001, {6'd0, 6'd0, 6'd0, 6'h2A}, 1, 0, 6'h00, 2'd0, 4'b1110, 1);
        tbl[1]  = mkv(0, 4'b0000, '0,                        1, 1, 6'h2A, 2'd0, 4'b1111, 1);
        tbl[2]  = mkv(0, 4'b0000, '0,                        1, 0, 6'h2A, 2'd0, 4'b1111, 0);
        tbl[3]  = mkv(1, 4'b1111, {6'd4, 6'd3, 6'd2, 6'd1},  1, 0, 6'h00, 2'd0, 4'b0000, 1);
        tbl[4]  = mkv(0, 4'b0000, '0,                        1, 1, 6'd1,  2'd0, 4'b0001, 1);
        tbl[5]  = mkv(0, 4'b0000, '0,                        1, 1, 6'd2,  2'd1, 4'b0011, 1);
        tbl[6]  = mkv(0, 4'b0000, '0,                        1, 1, 6'd3,  2'd2, 4'b0111, 1);
        tbl[7]  = mkv(0, 4'b0000, '0,                        1, 1, 6'd4,  2'd3, 4'b1111, 1);
        tbl[8]  = mkv(0, 4'b0000, '0,                        1, 0, 6'd4,  2'd3, 4'b1111, 0);
        tbl[9]  = mkv(0, 4'b1011, {6'h33, 6'd0, 6'h11, 6'h05}, 0, 0, 6'd4, 2'd3, 4'b0100, 1);
        for (int i = 10; i < 15; i++)
            tbl[i] = mkv(0, 4'b0000, '0,                     0, 1, 6'h05, 2'd0, 4'b0101, 1);
        tbl[15] = mkv(0, 4'b0000, '0,                        1, 1, 6'h11, 2'd1, 4'b0111, 1);
        tbl[16] = mkv(0, 4'b0000, '0,                        1, 1, 6'h33, 2'd3, 4'b1111, 1);
        tbl[17] = mkv(0, 4'b0000, '0,                        1, 0, 6'h33, 2'd3, 4'b1111, 0);

        for (int i = 0; i < 18; i++) begin
            if (tbl[i].do_reset) do_reset();
            step(tbl[i].iv, tbl[i].id, tbl[i].ordy);
            chk("vec", i, {18'd0, ov0, od0, os0, ir0, bz0},
                {18'd0, tbl[i].ev, tbl[i].ed, tbl[i].es, tbl[i].eir, tbl[i].eb});
        end

        // Requesters 0 and 2 always valid: round-robin alternates, fixed mode favours 0.
        do_reset();
        for (int k = 1; k <= 8; k++) begin
            f0 = !ir1[0];
            step(4'b0101, {6'd0, 6'h22, 6'd0, 6'h10}, 1);
            if (k >= 2) begin
                chk("rr_fair_valid", k, {31'd0, ov0}, 32'd1);
                chk("rr_fair_src", k, {30'd0, os0}, (k % 2 == 0) ? 32'd0 : 32'd2);
            end
            if (f0) chk("fp_win0", k, {30'd0, os1}, 32'd0);
        end

        // Async reset while holding a beat with three slots full.
        do_reset();
        step(4'b0111, {6'd0, 6'd3, 6'd2, 6'd1}, 0);
        step(4'b1000, {6'd4, 6'd0, 6'd0, 6'd0}, 0);
        chk("hold_pre_reset", 0, {26'd0, ov0, bz0, ir0}, {26'd0, 1'b1, 1'b1, 4'b0001});
        do_reset();
        step(4'b0100, {6'd0, 6'h17, 6'd0, 6'd0}, 1);
        chk("post_reset_accept", 0, {27'd0, ov0, ir0}, {27'd0, 1'b0, 4'b1011});
        step(4'b0000, '0, 1);
        chk("post_reset_grant", 0, {23'd0, ov0, od0, os0}, {23'd0, 1'b1, 6'h17, 2'd2});

        // Random traffic against the model and the per-requester scoreboard.
        do_reset();
        max_wait = 0;
        for (int c = 0; c < 10000; c++) begin
            step(4'($urandom_range(0, 15)), 24'($urandom), ($urandom_range(0, 3) != 0));
        end
        for (int c = 0; c < 8; c++) step(4'b0000, '0, 1);
        for (int i = 0; i < 4; i++) chk("sb_drained", i, 32'(sbq[i].size()), 32'd0);
        chk("rr_max_wait_le4", max_wait, {31'd0, (max_wait <= 4)}, 32'd1);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end
endmodule
